// File: rtl/rl_lj_force_accumulator_if.sv
// Stream bundle for rl_lj_force_accumulator: pair-force input, per-reference totals output.
// FORCE_ACC_PAIR_COUNT_EN adds out_pair_cnt (and the NEIGHBOR_CNT_WIDTH parameter).
interface rl_lj_force_accumulator_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int REF_ID_WIDTH = 7
`ifdef FORCE_ACC_PAIR_COUNT_EN
  , parameter int NEIGHBOR_CNT_WIDTH = 7
`endif
);
  logic                    start;
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_force_x;
  logic [DATA_WIDTH-1:0]   in_force_y;
  logic [DATA_WIDTH-1:0]   in_force_z;
  logic                    out_valid;
  logic [REF_ID_WIDTH-1:0] out_ref_id;
  logic [DATA_WIDTH-1:0]   out_force_x;
  logic [DATA_WIDTH-1:0]   out_force_y;
  logic [DATA_WIDTH-1:0]   out_force_z;
  logic                    done;
`ifdef FORCE_ACC_PAIR_COUNT_EN
  logic [NEIGHBOR_CNT_WIDTH:0] out_pair_cnt;

  modport master (output start, in_valid, in_force_x, in_force_y, in_force_z,
                  input  out_valid, out_ref_id, out_force_x, out_force_y, out_force_z, done, out_pair_cnt);
  modport slave  (input  start, in_valid, in_force_x, in_force_y, in_force_z,
                  output out_valid, out_ref_id, out_force_x, out_force_y, out_force_z, done, out_pair_cnt);
`else
  modport master (output start, in_valid, in_force_x, in_force_y, in_force_z,
                  input  out_valid, out_ref_id, out_force_x, out_force_y, out_force_z, done);
  modport slave  (input  start, in_valid, in_force_x, in_force_y, in_force_z,
                  output out_valid, out_ref_id, out_force_x, out_force_y, out_force_z, done);
`endif
endinterface

// File: rtl/rl_lj_force_accumulator.sv
// Sums NEIGHBOR_PARTICLE_NUM LJ pair forces per reference with L lane-interleaved FP adders, then drains lanes.
// Optional macro FORCE_ACC_PAIR_COUNT_EN adds a per-reference count of inside-cutoff (nonzero) pairs.
module rl_lj_force_accumulator #(
  parameter int DATA_WIDTH            = 32,
  parameter int REF_PARTICLE_NUM      = 100,
  parameter int REF_ID_WIDTH          = 7,
  parameter int NEIGHBOR_PARTICLE_NUM = 100,
  parameter int NEIGHBOR_CNT_WIDTH    = 7,
  parameter int ADDER_LATENCY         = 3
) (
  input logic clk,
  input logic rst,
  rl_lj_force_accumulator_if.slave bus
);
  localparam int L      = ADDER_LATENCY;
  localparam int LANE_W = (L > 1) ? $clog2(L) : 1;
  localparam int DEPTH  = L - 1;  // issue cycle + DEPTH registers = L cycles to the lane register

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [LANE_W-1:0]     lane_t;
  typedef struct packed { logic v; lane_t lane; logic last; logic fin; word_t x; word_t y; word_t z; } apipe_t;
  typedef struct packed { logic v; word_t x; word_t y; word_t z; } dpipe_t;
  typedef enum logic { IDLE, RUN } state_t;

  // IEEE-754 single add, round-to-nearest-even; denormals kept, NaN/Inf propagated.
  function automatic word_t fp_add(input word_t a, input word_t b);
    logic [31:0] big, sml;
    logic [7:0]  eb, es, d;
    logic [26:0] mb, ms, mask;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] m;
    logic        sticky;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    if (big[30:23] == 8'hff) begin
      if (big[22:0] != 23'd0) return big;
      if (sml[30:0] == 31'h7f80_0000 && sml[31] != big[31]) return 32'h7fc0_0000;
      return big;
    end
    eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    d  = eb - es;
    if (d > 8'd26) begin
      ms = {26'd0, |ms};
    end else begin
      mask   = (27'd1 << d) - 27'd1;
      sticky = |(ms & mask);
      ms     = (ms >> d) | {26'd0, sticky};
    end
    s = (big[31] == sml[31]) ? {1'b0, mb} + {1'b0, ms} : {1'b0, mb} - {1'b0, ms};
    if (s == 28'd0) return {big[31] & sml[31], 31'd0};
    e = {2'b00, eb};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26] && e > 10'd1) begin
        s = s << 1;
        e = e - 10'd1;
      end
    end
    m = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {big[31], 8'hff, 23'd0};
    return {big[31], (m[23] ? e[7:0] : 8'd0), m[22:0]};
  endfunction

  state_t                      state;
  logic [NEIGHBOR_CNT_WIDTH-1:0] pair_cnt;
  logic [REF_ID_WIDTH:0]       ref_cnt;
  lane_t                       lane_ptr;
  logic [L-1:0]                fresh;
  word_t                       lane_x [L], lane_y [L], lane_z [L];
  word_t                       drain_x [L], drain_y [L], drain_z [L];
  apipe_t                      apipe [DEPTH];
  dpipe_t                      dpipe [DEPTH];
  logic                        dr_load, dr_issue, dr_fin;
  lane_t                       dr_m;
  word_t                       acc_x, acc_y, acc_z;
  logic [REF_ID_WIDTH-1:0]     drain_ref;
  logic                        res_valid, res_done;
  logic [REF_ID_WIDTH-1:0]     res_ref_id;
  word_t                       res_x, res_y, res_z;

  logic   accept;
  apipe_t issue, wb;
  dpipe_t dsum, dwb;
  word_t  addend_x, addend_y, addend_z;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    accept   = (state == RUN) && bus.in_valid && (ref_cnt < (REF_ID_WIDTH+1)'(REF_PARTICLE_NUM));
    addend_x = fresh[lane_ptr] ? '0 : lane_x[lane_ptr];
    addend_y = fresh[lane_ptr] ? '0 : lane_y[lane_ptr];
    addend_z = fresh[lane_ptr] ? '0 : lane_z[lane_ptr];
    issue.v    = accept;
    issue.lane = lane_ptr;
    issue.last = pair_cnt >= NEIGHBOR_CNT_WIDTH'(NEIGHBOR_PARTICLE_NUM - L);
    issue.fin  = pair_cnt == NEIGHBOR_CNT_WIDTH'(NEIGHBOR_PARTICLE_NUM - 1);
    issue.x    = fp_add(bus.in_force_x, addend_x);
    issue.y    = fp_add(bus.in_force_y, addend_y);
    issue.z    = fp_add(bus.in_force_z, addend_z);
    wb         = apipe[DEPTH-1];
    dsum.v     = dr_issue;
    dsum.x     = fp_add(acc_x, drain_x[dr_m]);
    dsum.y     = fp_add(acc_y, drain_y[dr_m]);
    dsum.z     = fp_add(acc_z, drain_z[dr_m]);
    dwb        = dpipe[DEPTH-1];
  end

`ifdef FORCE_ACC_PAIR_COUNT_EN
  logic [NEIGHBOR_CNT_WIDTH:0] nz_cnt, nz_hold, res_pair_cnt;
  logic                        nz;
  assign nz = (|bus.in_force_x[DATA_WIDTH-2:0]) | (|bus.in_force_y[DATA_WIDTH-2:0]) |
              (|bus.in_force_z[DATA_WIDTH-2:0]);

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      nz_cnt       <= '0;
      nz_hold      <= '0;
      res_pair_cnt <= '0;
    end else begin
      if (accept) begin
        if (issue.fin) begin
          nz_hold <= nz_cnt + {{NEIGHBOR_CNT_WIDTH{1'b0}}, nz};
          nz_cnt  <= '0;
        end else begin
          nz_cnt  <= nz_cnt + {{NEIGHBOR_CNT_WIDTH{1'b0}}, nz};
        end
      end
      if (dr_fin) res_pair_cnt <= nz_hold;
    end
  end
  assign bus.out_pair_cnt = res_pair_cnt;
`endif

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      state     <= rst ? IDLE : RUN;
      pair_cnt  <= '0;
      ref_cnt   <= '0;
      lane_ptr  <= '0;
      fresh     <= '1;
      // NOTE: lane/drain arrays are reset too, so a restart can never leak partial sums.
      for (int i = 0; i < L; i++) begin
        lane_x[i]  <= '0; lane_y[i]  <= '0; lane_z[i]  <= '0;
        drain_x[i] <= '0; drain_y[i] <= '0; drain_z[i] <= '0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        apipe[k] <= '0;
        dpipe[k] <= '0;
      end
      dr_load    <= 1'b0;
      dr_issue   <= 1'b0;
      dr_fin     <= 1'b0;
      dr_m       <= '0;
      acc_x      <= '0; acc_y <= '0; acc_z <= '0;
      drain_ref  <= '0;
      res_valid  <= 1'b0;
      res_done   <= 1'b0;
      res_ref_id <= '0;
      res_x      <= '0; res_y <= '0; res_z <= '0;
    end else begin
      apipe[0] <= issue;
      dpipe[0] <= dsum;
      for (int k = 1; k < DEPTH; k++) begin
        apipe[k] <= apipe[k-1];
        dpipe[k] <= dpipe[k-1];
      end

      if (accept) begin
        fresh[lane_ptr] <= 1'b0;
        lane_ptr        <= (lane_ptr == lane_t'(L - 1)) ? '0 : lane_ptr + 1'b1;
        if (issue.fin) begin
          pair_cnt <= '0;
          ref_cnt  <= ref_cnt + 1'b1;
          fresh    <= '1;
        end else begin
          pair_cnt <= pair_cnt + 1'b1;
        end
      end

      if (wb.v) begin
        lane_x[wb.lane] <= wb.x;
        lane_y[wb.lane] <= wb.y;
        lane_z[wb.lane] <= wb.z;
        if (wb.last) begin
          drain_x[wb.lane] <= wb.x;
          drain_y[wb.lane] <= wb.y;
          drain_z[wb.lane] <= wb.z;
        end
      end

      // Drain: acc = buf[0], then one add per L cycles over buf[1..L-1], then register totals.
      dr_load  <= wb.v && wb.fin;
      dr_issue <= 1'b0;
      dr_fin   <= 1'b0;
      if (dr_load) begin
        acc_x    <= drain_x[0];
        acc_y    <= drain_y[0];
        acc_z    <= drain_z[0];
        dr_m     <= lane_t'(1);
        dr_issue <= 1'b1;
      end
      if (dwb.v) begin
        acc_x <= dwb.x;
        acc_y <= dwb.y;
        acc_z <= dwb.z;
        if (dr_m == lane_t'(L - 1)) begin
          dr_fin <= 1'b1;
        end else begin
          dr_m     <= dr_m + 1'b1;
          dr_issue <= 1'b1;
        end
      end

      res_valid <= dr_fin;
      res_done  <= 1'b0;
      if (dr_fin) begin
        res_x      <= acc_x;
        res_y      <= acc_y;
        res_z      <= acc_z;
        res_ref_id <= drain_ref;
        drain_ref  <= drain_ref + 1'b1;
        if (drain_ref == REF_ID_WIDTH'(REF_PARTICLE_NUM - 1)) begin
          res_done <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end

  assign bus.out_valid   = res_valid;
  assign bus.out_ref_id  = res_ref_id;
  assign bus.out_force_x = res_x;
  assign bus.out_force_y = res_y;
  assign bus.out_force_z = res_z;
  assign bus.done        = res_done;
endmodule

// File: tb/tb_rl_lj_force_accumulator.sv
// Directed bench for rl_lj_force_accumulator with L=3, N=16, REF=2; totals and latency hand-computed.
module tb_rl_lj_force_accumulator;
  localparam int DW = 32, REF = 2, RIW = 1, N = 16, NCW = 4, L = 3, LAT = L * L + 2;
  localparam logic [31:0] ZERO = 32'h0000_0000, NEGZ = 32'h8000_0000, ONE = 32'h3F80_0000,
                          TWO = 32'h4000_0000, MHALF = 32'hBF00_0000, F5 = 32'h40A0_0000,
                          F10 = 32'h4120_0000, F16 = 32'h4180_0000, F32 = 32'h4200_0000,
                          M8 = 32'hC100_0000, F120 = 32'h42F0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef FORCE_ACC_PAIR_COUNT_EN
  rl_lj_force_accumulator_if #(.DATA_WIDTH(DW), .REF_ID_WIDTH(RIW), .NEIGHBOR_CNT_WIDTH(NCW)) bus ();
`else
  rl_lj_force_accumulator_if #(.DATA_WIDTH(DW), .REF_ID_WIDTH(RIW)) bus ();
`endif

  rl_lj_force_accumulator #(
    .DATA_WIDTH(DW), .REF_PARTICLE_NUM(REF), .REF_ID_WIDTH(RIW),
    .NEIGHBOR_PARTICLE_NUM(N), .NEIGHBOR_CNT_WIDTH(NCW), .ADDER_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { int cyc; logic [RIW-1:0] id; logic [31:0] x; logic [31:0] y; logic [31:0] z;
                   logic done; logic [NCW:0] pc; } ev_t;
  ev_t ev_q[$];
  int  last_q[$];
  int  stray_done = 0;
  int  passed = 0, fails = 0, total = 0;
  logic [31:0] int_f [16] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                              32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000,
                              32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
                              32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000};

  always @(negedge clk) begin
    if (bus.out_valid) begin
      ev_t e;
      e.cyc  = cyc;
      e.id   = bus.out_ref_id;
      e.x    = bus.out_force_x;
      e.y    = bus.out_force_y;
      e.z    = bus.out_force_z;
      e.done = bus.done;
`ifdef FORCE_ACC_PAIR_COUNT_EN
      e.pc   = bus.out_pair_cnt;
`else
      e.pc   = '0;
`endif
      ev_q.push_back(e);
    end else if (bus.done) begin
      stray_done++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input bit mark);
    bus.in_valid   = 1'b1;
    bus.in_force_x = x;
    bus.in_force_y = y;
    bus.in_force_z = z;
    if (mark) last_q.push_back(cyc);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ev_q.delete();
    last_q.delete();
  endtask

  task automatic wait_events(input string tag, input int n);
    for (int i = 0; i < 300 && ev_q.size() < n; i++) tick();
    check({tag, "_count"}, ev_q.size(), n);
  endtask

  task automatic check_ev(input string tag, input int k, input logic [RIW-1:0] id,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input logic [NCW:0] pc, input logic dn);
    if (ev_q.size() > k) begin
      check({tag, "_id"}, ev_q[k].id, id);
      check({tag, "_x"}, ev_q[k].x, x);
      check({tag, "_y"}, ev_q[k].y, y);
      check({tag, "_z"}, ev_q[k].z, z);
      check({tag, "_done"}, ev_q[k].done, dn);
`ifdef FORCE_ACC_PAIR_COUNT_EN
      check({tag, "_pair_cnt"}, ev_q[k].pc, pc);
`endif
      if (last_q.size() > k) check({tag, "_latency"}, ev_q[k].cyc - last_q[k], LAT);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.in_force_x = '0; bus.in_force_y = '0; bus.in_force_z = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_ref_id", bus.out_ref_id, 0);
    check("rst_force_x", bus.out_force_x, 0);
    check("rst_force_y", bus.out_force_y, 0);
    check("rst_force_z", bus.out_force_z, 0);
`ifdef FORCE_ACC_PAIR_COUNT_EN
    check("rst_pair_cnt", bus.out_pair_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // in_valid before any start must be ignored
    for (int i = 0; i < 4; i++) pair(F5, F5, F5, 1'b0);
    repeat (20) tick();
    check("idle_no_output", ev_q.size(), 0);

    // back-to-back constant pairs
    pulse_start();
    for (int i = 0; i < 2 * N; i++) pair(ONE, TWO, MHALF, (i % N) == N - 1);
    wait_events("const", 2);
    check_ev("const_r0", 0, 0, F16, F32, M8, 16, 1'b0);
    check_ev("const_r1", 1, 1, F16, F32, M8, 16, 1'b1);
    for (int i = 0; i < 4; i++) pair(ONE, ONE, ONE, 1'b0);
    repeat (20) tick();
    check("post_done_quiet", ev_q.size(), 2);

    // ramp 0..15 with random gaps
    pulse_start();
    for (int r = 0; r < REF; r++)
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        pair(int_f[i], ZERO, ZERO, i == N - 1);
      end
    wait_events("ramp", 2);
    check_ev("ramp_r0", 0, 0, F120, ZERO, ZERO, 15, 1'b0);
    check_ev("ramp_r1", 1, 1, F120, ZERO, ZERO, 15, 1'b1);

    // no carry-over from a ref of ones into a ref of zeros
    pulse_start();
    for (int i = 0; i < N; i++) pair(ONE, ONE, ONE, i == N - 1);
    for (int i = 0; i < N; i++) pair(ZERO, ZERO, ZERO, i == N - 1);
    wait_events("carry", 2);
    check_ev("carry_r0", 0, 0, F16, F16, F16, 16, 1'b0);
    check_ev("carry_r1", 1, 1, ZERO, ZERO, ZERO, 0, 1'b1);

    // reset five cycles into the drain of ref 0
    pulse_start();
    for (int i = 0; i < N; i++) pair(ONE, ONE, ONE, i == N - 1);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rst_drain_no_output", ev_q.size(), 0);
    check("rst_drain_force_x", bus.out_force_x, 0);
    check("rst_drain_ref_id", bus.out_ref_id, 0);
    pulse_start();
    for (int i = 0; i < 2 * N; i++) pair(TWO, ONE, MHALF, (i % N) == N - 1);
    wait_events("after_rst", 2);
    check_ev("after_rst_r0", 0, 0, F32, F16, M8, 16, 1'b0);
    check_ev("after_rst_r1", 1, 1, F32, F16, M8, 16, 1'b1);

    // second start mid-run restarts counters and sums
    pulse_start();
    for (int i = 0; i < 10; i++) pair(TWO, TWO, TWO, 1'b0);
    pulse_start();
    for (int i = 0; i < 2 * N; i++) pair(ONE, ONE, ONE, (i % N) == N - 1);
    wait_events("restart", 2);
    check_ev("restart_r0", 0, 0, F16, F16, F16, 16, 1'b0);
    check_ev("restart_r1", 1, 1, F16, F16, F16, 16, 1'b1);

    // 10 nonzero pairs and 6 negative-zero pairs per reference
    pulse_start();
    for (int i = 0; i < 2 * N; i++) begin
      if ((i % 8) < 5) pair(ONE, ZERO, ZERO, (i % N) == N - 1);
      else             pair(NEGZ, ZERO, ZERO, (i % N) == N - 1);
    end
    wait_events("cutoff", 2);
    check_ev("cutoff_r0", 0, 0, F10, ZERO, ZERO, 10, 1'b0);
    check_ev("cutoff_r1", 1, 1, F10, ZERO, ZERO, 10, 1'b1);

    check("stray_done", stray_done, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
